// File: rtl/xorlfsr_cmd_sequencer.sv
// Host command front-end for the 8-lane XOR-LFSR keystream core.
// Optional: XORSEQ_AUTOSEED_EN pulses setseed after every seed load.
module xorlfsr_cmd_sequencer #(
    parameter logic [7:0] OP_LOAD    = 8'h01,
    parameter logic [7:0] OP_SET     = 8'h02,
    parameter logic [7:0] OP_STREAM  = 8'h03,
    parameter int         SEED_BYTES = 16
) (
    input  logic       dataclk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       err,
    output logic [7:0] core_datain,
    output logic       core_seeddata,
    output logic       core_setseed,
    output logic       core_streamdata,
    input  logic [7:0] core_dataout
);

    localparam int CW = (SEED_BYTES > 1) ? $clog2(SEED_BYTES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SEED_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETP,
        S_LEN,
        S_STRM
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [8:0]      rem_q;
    logic            rdy_q;
    logic            ov_q;
    logic            err_q;
    logic            seed_q;
    logic            set_q;
    logic            strm_q;
    logic [7:0]      din_q;
    logic            acc;

    assign acc = in_valid & rdy_q;

    // Command FSM; every output is a register, strobes default low.
    always_ff @(posedge dataclk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            rdy_q   <= 1'b0;
            ov_q    <= 1'b0;
            err_q   <= 1'b0;
            seed_q  <= 1'b0;
            set_q   <= 1'b0;
            strm_q  <= 1'b0;
            din_q   <= '0;
        end else begin
            seed_q <= 1'b0;
            set_q  <= 1'b0;
            strm_q <= 1'b0;
            rdy_q  <= 1'b1;
            ov_q   <= strm_q;
            unique case (state_q)
                S_IDLE: begin
                    if (acc) begin
                        if (in_data == OP_LOAD) begin
                            state_q <= S_LOAD;
                            cnt_q   <= '0;
                        end else if (in_data == OP_SET) begin
                            state_q <= S_SETP;
                            rdy_q   <= 1'b0;
                        end else if (in_data == OP_STREAM) begin
                            state_q <= S_LEN;
                        end else begin
                            err_q   <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (acc) begin
                        din_q  <= in_data;
                        seed_q <= 1'b1;
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
`ifdef XORSEQ_AUTOSEED_EN
                            state_q <= S_SETP;
                            rdy_q   <= 1'b0;
`else
                            state_q <= S_IDLE;
`endif
                        end
                    end
                end
                S_SETP: begin
                    set_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
                S_LEN: begin
                    if (acc) begin
                        if (in_data == 8'd0) begin
                            rem_q <= 9'd256;
                        end else begin
                            rem_q <= {1'b0, in_data};
                        end
                        state_q <= S_STRM;
                    end
                end
                S_STRM: begin
                    if (acc) begin
                        din_q  <= in_data;
                        strm_q <= 1'b1;
                        rem_q  <= rem_q - 9'd1;
                        if (rem_q == 9'd1) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready        = rdy_q;
    assign out_valid       = ov_q;
    assign out_data        = core_dataout;
    assign err             = err_q;
    assign core_datain     = din_q;
    assign core_seeddata   = seed_q;
    assign core_setseed    = set_q;
    assign core_streamdata = strm_q;

endmodule

// File: tb/tb_xorlfsr_cmd_sequencer.sv
// Directed bench for xorlfsr_cmd_sequencer with a fixed-key core stand-in.
// Honors XORSEQ_AUTOSEED_EN when the design is built with it.
module tb_xorlfsr_cmd_sequencer;

    localparam logic [7:0] KEY = 8'h3C;

    logic       dataclk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       err;
    logic [7:0] core_datain;
    logic       core_seeddata;
    logic       core_setseed;
    logic       core_streamdata;
    logic [7:0] core_dataout = 8'h00;

    int checks = 0;
    int failures = 0;

    logic [7:0] seed_log[$];
    logic [7:0] ov_log[$];
    int set_cnt = 0;
    int strm_cnt = 0;
    int excl_bad = 0;
    int lat_bad = 0;
    logic prev_strm = 1'b0;
    logic mon_en = 1'b0;

    xorlfsr_cmd_sequencer dut (
        .dataclk        (dataclk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .err            (err),
        .core_datain    (core_datain),
        .core_seeddata  (core_seeddata),
        .core_setseed   (core_setseed),
        .core_streamdata(core_streamdata),
        .core_dataout   (core_dataout)
    );

    always #5 dataclk = ~dataclk;

    // Core stand-in: registers datain ^ fixed key on streamdata.
    always @(posedge dataclk) begin
        if (core_streamdata === 1'b1) core_dataout <= core_datain ^ KEY;
    end

    // Mid-cycle monitor of strobes and output pulses.
    always @(negedge dataclk) begin
        if (mon_en) begin
            if (core_seeddata) seed_log.push_back(core_datain);
            if (core_setseed) set_cnt++;
            if (core_streamdata) strm_cnt++;
            if (out_valid) ov_log.push_back(out_data);
            if (int'(core_seeddata) + int'(core_setseed)
                + int'(core_streamdata) > 1) excl_bad++;
            if (out_valid !== prev_strm) lat_bad++;
        end
        prev_strm = core_streamdata & ~reset;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge dataclk);
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge dataclk);
            n++;
        end
        if (in_ready !== 1'b1) chk("rdy_wait", 32'(in_ready), 32'd1);
        @(posedge dataclk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge dataclk);
        #1;
    endtask

    int s0, o0, t0, p0;
    logic [7:0] b;

    initial begin
        // Test 1: reset with in_valid high
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h01;
        repeat (3) @(posedge dataclk);
        #1;
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_seed", 32'(core_seeddata), 32'd0);
        chk("rst_set", 32'(core_setseed), 32'd0);
        chk("rst_strm", 32'(core_streamdata), 32'd0);
        chk("rst_datain", 32'(core_datain), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ov", 32'(out_valid), 32'd0);
        reset = 1'b0;
        in_valid = 1'b0;
        mon_en = 1'b1;
        idle(1);
        chk("idle_ready", 32'(in_ready), 32'd1);

        // Test 2: seed load then setseed
        send(8'h01);
        for (int i = 0; i < 16; i++) send(8'(i));
`ifndef XORSEQ_AUTOSEED_EN
        send(8'h02);
`endif
        chk("setp_ready", 32'(in_ready), 32'd0);
        idle(3);
        chk("seed_cnt", 32'(seed_log.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < seed_log.size())
                chk("seed_data", 32'(seed_log[i]), 32'(i));
        end
        chk("set_cnt", 32'(set_cnt), 32'd1);
        chk("ready_back", 32'(in_ready), 32'd1);

        // Test 3: four-byte stream
        o0 = ov_log.size();
        t0 = strm_cnt;
        send(8'h03);
        send(8'h04);
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        send(8'hDD);
        idle(4);
        chk("s4_strm", 32'(strm_cnt - t0), 32'd4);
        chk("s4_ov", 32'(ov_log.size() - o0), 32'd4);
        if (ov_log.size() >= o0 + 4) begin
            chk("s4_d0", 32'(ov_log[o0]), 32'h96);
            chk("s4_d1", 32'(ov_log[o0+1]), 32'h87);
            chk("s4_d2", 32'(ov_log[o0+2]), 32'hF0);
            chk("s4_d3", 32'(ov_log[o0+3]), 32'hE1);
        end

        // Test 4: length 0 means 256
        o0 = ov_log.size();
        send(8'h03);
        send(8'h00);
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            send(b);
        end
        idle(4);
        chk("s256_ov", 32'(ov_log.size() - o0), 32'd256);
        if (ov_log.size() >= o0 + 256) begin
            chk("s256_first", 32'(ov_log[o0]), 32'h3C);
            chk("s256_last", 32'(ov_log[o0+255]), 32'hC3);
        end
        p0 = set_cnt;
        send(8'h02);
        idle(3);
        chk("s256_set", 32'(set_cnt - p0), 32'd1);

        // Test 5: unknown opcode
        s0 = seed_log.size();
        t0 = strm_cnt;
        p0 = set_cnt;
        send(8'h7F);
        idle(3);
        chk("err_set", 32'(err), 32'd1);
        chk("err_seed", 32'(seed_log.size() - s0), 32'd0);
        chk("err_strm", 32'(strm_cnt - t0), 32'd0);
        chk("err_setc", 32'(set_cnt - p0), 32'd0);
        send(8'h02);
        idle(3);
        chk("err_then_set", 32'(set_cnt - p0), 32'd1);
        chk("err_sticky", 32'(err), 32'd1);

        // Test 6: reset in the middle of a stream
        t0 = strm_cnt;
        p0 = set_cnt;
        send(8'h03);
        send(8'h04);
        send(8'h11);
        send(8'h22);
        in_data = 8'h33;
        reset = 1'b1;
        repeat (2) @(posedge dataclk);
        #1;
        reset = 1'b0;
        idle(3);
        chk("rst_mid_strm", 32'(strm_cnt - t0), 32'd2);
        chk("rst_mid_err", 32'(err), 32'd0);
        s0 = seed_log.size();
        send(8'h01);
        for (int i = 0; i < 16; i++) send(8'(8'h20 + i));
        idle(4);
        chk("reload_cnt", 32'(seed_log.size() - s0), 32'd16);
        if (seed_log.size() >= s0 + 16) begin
            chk("reload_first", 32'(seed_log[s0]), 32'h20);
            chk("reload_last", 32'(seed_log[s0+15]), 32'h2F);
        end
        chk("rst_mid_strm2", 32'(strm_cnt - t0), 32'd2);
`ifdef XORSEQ_AUTOSEED_EN
        chk("reload_set", 32'(set_cnt - p0), 32'd1);
`else
        chk("reload_set", 32'(set_cnt - p0), 32'd0);
`endif

        chk("exclusive", 32'(excl_bad), 32'd0);
        chk("latency", 32'(lat_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
